tpu_mmio_loader: RTL and testbench

TPU_MMIO_LOADER -- requirements
Module: tpu_mmio_loader

---
 rtl/tpu_mmio_loader.sv | 262 ++++++++++++++++++++++++++
 tb/tb_tpu_mmio_loader.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_mmio_loader.sv
// -----------------------------------------------------------------------------
// tpu_mmio_loader
//
// Purpose:
//   MMIO-programmable byte buffer that streams its first LEN bytes to the
//   systolic array as little-endian 32-bit words. Software fills the buffer,
//   programs LEN and writes START; the block then emits ceil(LEN/4) words on a
//   valid/ready stream, marking the final word with out_last.
//
// Register map (byte addresses):
//   0x0000 CTRL   W : bit0 START, bit1 SOFT_RST, bit2 DONE_CLR (self-clearing, reads 0)
//   0x0004 STATUS RO: bit0 BUSY, bit1 DONE, bit2 ERR
//   0x0008 LEN    RW: [8:0] byte count
//   0x000C PERF   RO: cycles spent streaming (0 unless TPU_LOADER_PERF_EN)
//   0x1000 ..     byte buffer, BUF_BYTES entries
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mmio_wr / mmio_rd         request, held by the master until mmio_ready
//   mmio_addr[15:0]           byte address
//   mmio_wdata[31:0]          write data (buffer writes use [7:0])
//   mmio_wstrb[3:0]           lane strobe, a write needs any bit set
//   mmio_rdata[31:0]          read data, valid while mmio_ready
//   mmio_ready                one-cycle completion pulse, one cycle after accept
//   out_valid/out_data/out_last, out_ready   word stream to the array
//
// Configuration:
//   TPU_LOADER_PERF_EN  when defined, PERF counts STREAM cycles (incl. stalls),
//                       cleared on START, saturating. Undefined: PERF reads 0.
// -----------------------------------------------------------------------------
module tpu_mmio_loader #(
  parameter int BUF_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_wr,
  input  logic        mmio_rd,
  input  logic [15:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  input  logic [3:0]  mmio_wstrb,
  output logic [31:0] mmio_rdata,
  output logic        mmio_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready
);

  localparam int AW = $clog2(BUF_BYTES);

  localparam logic [15:0] ADDR_CTRL   = 16'h0000;
  localparam logic [15:0] ADDR_STATUS = 16'h0004;
  localparam logic [15:0] ADDR_LEN    = 16'h0008;
  localparam logic [15:0] ADDR_PERF   = 16'h000C;
  localparam logic [15:0] BUF_BASE    = 16'h1000;
  localparam logic [9:0]  BUF_SIZE    = 10'(BUF_BYTES);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t      state;
  logic [8:0]  len;
  logic        done;
  logic        err;
  logic [9:0]  byte_ptr;      // byte offset of the word currently on out_data
  logic [7:0]  buf_mem [BUF_BYTES];
  logic [31:0] perf_value;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  // A held request is accepted once: while mmio_ready is high it is masked,
  // and the master has dropped or replaced it by the following cycle.
  logic req_accept;
  logic wr_en;
  logic busy;
  logic buf_hit;
  logic [AW-1:0] buf_off;
  logic ctrl_wr;
  logic start_req;
  logic soft_rst_req;
  logic done_clr_req;
  logic len_wr;
  logic buf_wr;

  assign req_accept   = (mmio_wr || mmio_rd) && !mmio_ready;
  assign wr_en        = req_accept && mmio_wr && (mmio_wstrb != 4'b0000);
  assign busy         = (state == STREAM);
  assign buf_hit      = (mmio_addr[15:AW] == BUF_BASE[15:AW]);
  assign buf_off      = mmio_addr[AW-1:0];
  assign ctrl_wr      = wr_en && (mmio_addr == ADDR_CTRL);
  assign start_req    = ctrl_wr && mmio_wdata[0];
  assign soft_rst_req = ctrl_wr && mmio_wdata[1];
  assign done_clr_req = ctrl_wr && mmio_wdata[2];
  assign len_wr       = wr_en && (mmio_addr == ADDR_LEN);
  assign buf_wr       = wr_en && buf_hit;

  // Upper write-data bits have no destination in this register map.
  logic unused_wdata;
  assign unused_wdata = ^mmio_wdata[31:9];

  // ---------------------------------------------------------------------------
  // Byte buffer
  // ---------------------------------------------------------------------------
  // NOTE: the buffer has no reset; clearing a RAM-style array on reset would
  // turn it into a large bank of resettable flops for no functional gain.
  // Writes while streaming are dropped so the word in flight stays stable.
  always_ff @(posedge clk) begin
    if (!rst && buf_wr && !busy) begin
      buf_mem[buf_off] <= mmio_wdata[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] rd_value;

  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    rd_value = '0;
    if (buf_hit) begin
      rd_value = {24'h000000, buf_mem[buf_off]};
    end else begin
      case (mmio_addr)
        ADDR_STATUS: rd_value = {29'd0, err, done, busy};
        ADDR_LEN:    rd_value = {23'd0, len};
        ADDR_PERF:   rd_value = perf_value;
        default:     rd_value = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next stream word
  // ---------------------------------------------------------------------------
  // In IDLE this is word 0 (loaded on START); in STREAM it is the word after
  // the one on out_data (loaded on a transfer). Bytes at or past LEN read 0.
  logic [9:0]  load_base;
  logic [31:0] word_next;
  logic        last_next;

  always_comb begin
    load_base = busy ? (byte_ptr + 10'd4) : 10'd0;
    word_next = '0;
    for (int k = 0; k < 4; k++) begin
      if ((load_base + 10'(k)) < {1'b0, len}) begin
        word_next[8*k +: 8] = buf_mem[AW'(load_base + 10'(k))];
      end
    end
    last_next = ((load_base + 10'd4) >= {1'b0, len});
  end

  // ---------------------------------------------------------------------------
  // Optional cycle counter
  // ---------------------------------------------------------------------------
`ifdef TPU_LOADER_PERF_EN
  logic [31:0] perf;

  always_ff @(posedge clk) begin
    if (rst || soft_rst_req) begin
      perf <= '0;
    end else if (start_req && !busy && (len != 9'd0) && ({1'b0, len} <= BUF_SIZE)) begin
      perf <= '0;
    end else if (busy && (perf != 32'hFFFF_FFFF)) begin
      perf <= perf + 32'd1;
    end
  end

  assign perf_value = perf;
`else
  assign perf_value = '0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM, MMIO response and stream registers
  // ---------------------------------------------------------------------------
  // NOTE: all state in this block uses non-blocking assignments, so later
  // statements override earlier ones at the same edge; the ordering below
  // encodes the priorities (DONE set beats DONE_CLR, SOFT_RST beats all).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mmio_ready <= 1'b0;
      mmio_rdata <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      len        <= '0;
      byte_ptr   <= '0;
    end else begin
      mmio_ready <= req_accept;
      mmio_rdata <= (req_accept && mmio_rd) ? rd_value : '0;

      if (len_wr) begin
        if (busy) begin
          err <= 1'b1;
        end else begin
          len <= mmio_wdata[8:0];
        end
      end

      if (buf_wr && busy) begin
        err <= 1'b1;
      end

      if (done_clr_req) begin
        done <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_req) begin
            if (len == 9'd0) begin
              done <= 1'b1;
            end else if ({1'b0, len} > BUF_SIZE) begin
              err <= 1'b1;
            end else begin
              done      <= 1'b0;
              state     <= STREAM;
              byte_ptr  <= '0;
              out_valid <= 1'b1;
              out_data  <= word_next;
              out_last  <= last_next;
            end
          end
        end

        STREAM: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
              done      <= 1'b1;
            end else begin
              byte_ptr <= byte_ptr + 10'd4;
              out_data <= word_next;
              out_last <= last_next;
            end
          end
        end

        default: state <= IDLE;
      endcase

      if (soft_rst_req) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        done      <= 1'b0;
        err       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tpu_mmio_loader.sv
// -----------------------------------------------------------------------------
// tb_tpu_mmio_loader
//
// Self-checking bench for tpu_mmio_loader. A byte model of the buffer builds
// the expected word stream when START is issued; a negedge monitor pops and
// compares each transferred beat. Register reads are compared inline.
// -----------------------------------------------------------------------------
module tb_tpu_mmio_loader;

  localparam int BUF_BYTES = 256;

  localparam logic [15:0] A_CTRL   = 16'h0000;
  localparam logic [15:0] A_STATUS = 16'h0004;
  localparam logic [15:0] A_LEN    = 16'h0008;
  localparam logic [15:0] A_PERF   = 16'h000C;
  localparam logic [15:0] A_BUF    = 16'h1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [15:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [3:0]  mmio_wstrb;
  logic [31:0] mmio_rdata;
  logic        mmio_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;

  tpu_mmio_loader #(.BUF_BYTES(BUF_BYTES)) dut (
    .clk        (clk),
    .rst        (rst),
    .mmio_wr    (mmio_wr),
    .mmio_rd    (mmio_rd),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_wstrb (mmio_wstrb),
    .mmio_rdata (mmio_rdata),
    .mmio_ready (mmio_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  logic [7:0]  model_buf [BUF_BYTES];
  int          checks = 0;
  int          errors = 0;

  // Beat monitor: a beat sampled here with valid&&ready transfers at the next
  // rising edge (inputs only change just after rising edges).
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data=%h last=%b, required no beat", out_data, out_last);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_data !== mon_e.data || out_last !== mon_e.last) begin
          errors++;
          $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                   out_data, out_last, mon_e.data, mon_e.last);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers (stimulus only; every comparison lives in a test task)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every MMIO access also checks the one-cycle completion latency.
  task automatic mmio_access(input logic is_wr, input logic [15:0] a, input logic [31:0] d,
                             output logic [31:0] rd);
    mmio_addr  = a;
    mmio_wdata = d;
    mmio_wstrb = 4'hF;
    mmio_wr    = is_wr;
    mmio_rd    = !is_wr;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mmio_ready !== 1'b1) begin
      errors++;
      $display("FAIL mmio_latency: addr=%h got ready=%b, required 1", a, mmio_ready);
    end
    rd = mmio_rdata;
    @(posedge clk);
    #1;
    mmio_wr = 1'b0;
    mmio_rd = 1'b0;
  endtask

  task automatic mmio_write(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    mmio_access(1'b1, a, d, dummy);
  endtask

  task automatic mmio_read(input logic [15:0] a, output logic [31:0] d);
    mmio_access(1'b0, a, 32'h0, d);
  endtask

  // Upper bits carry junk so only [7:0] may land in the buffer.
  task automatic write_byte(input int off, input logic [7:0] v);
    model_buf[off] = v;
    mmio_write(A_BUF + 16'(off), {24'hA5C3E1, v});
  endtask

  function automatic void push_stream(input int len);
    beat_t b;
    int nw;
    nw = (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      b.data = '0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < len) b.data[8*k +: 8] = model_buf[4*w + k];
      end
      b.last = (w == nw - 1);
      exp_q.push_back(b);
    end
  endfunction

  task automatic wait_drain(input int max_cycles, input bit rand_ready);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < max_cycles) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words pending valid=%b, required 0 pending", exp_q.size(), out_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1; mmio_wr = 1'b0; mmio_rd = 1'b0; mmio_addr = '0;
    mmio_wdata = '0; mmio_wstrb = '0; out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, mmio_ready, out_data, mmio_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b last=%b ready=%b data=%h rdata=%h, required all 0",
               out_valid, out_last, mmio_ready, out_data, mmio_rdata);
    end
    tick();
    rst = 1'b0;
    tick();
    mmio_read(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h required %h", rd, 32'h0); end
    mmio_read(A_LEN, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_len: got %h required %h", rd, 32'h0); end
    mmio_read(A_PERF, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_perf: got %h required %h", rd, 32'h0); end
    mmio_read(A_CTRL, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ctrl_reads_zero: got %h required %h", rd, 32'h0); end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    for (int i = 0; i < 8; i++) write_byte(i, 8'(i + 1));
    mmio_write(A_LEN, 32'd8);
    mmio_read(A_LEN, rd);
    checks++; if (rd !== 32'd8) begin errors++; $display("FAIL len_readback: got %h required %h", rd, 32'd8); end
    mmio_read(A_BUF + 16'd3, rd);
    checks++; if (rd !== 32'h04) begin errors++; $display("FAIL buf_readback: got %h required %h", rd, 32'h04); end
    mmio_read(16'h0010, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h required %h", rd, 32'h0); end
    push_stream(8);
    mmio_write(A_CTRL, 32'h1);
    wait_drain(50, 1'b0);
    mmio_read(A_STATUS, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL basic_done: got %h required %h", rd, 32'h2); end
  endtask

  task automatic test_partial();
    logic [31:0] rd;
    int lens[4] = '{5, 1, 4, 7};
    foreach (lens[i]) begin
      mmio_write(A_CTRL, 32'h4);
      mmio_read(A_STATUS, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL done_clr: got %h required %h", rd, 32'h0); end
      mmio_write(A_LEN, 32'(lens[i]));
      push_stream(lens[i]);
      mmio_write(A_CTRL, 32'h1);
      wait_drain(50, 1'b0);
      mmio_read(A_STATUS, rd);
      checks++; if (rd !== 32'h2) begin errors++; $display("FAIL partial_done len=%0d: got %h required %h", lens[i], rd, 32'h2); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] rd;
    logic [31:0] exp_perf;
    mmio_write(A_LEN, 32'd8);
    out_ready = 1'b0;
    push_stream(8);
    mmio_write(A_CTRL, 32'h1);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0].data || out_last !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b data=%h last=%b, required valid=1 data=%h last=0",
                 out_valid, out_data, out_last, exp_q[0].data);
      end
      tick();
    end
    out_ready = 1'b1;
    wait_drain(50, 1'b0);
`ifdef TPU_LOADER_PERF_EN
    exp_perf = 32'd5;
`else
    exp_perf = 32'd0;
`endif
    mmio_read(A_PERF, rd);
    checks++; if (rd !== exp_perf) begin errors++; $display("FAIL perf: got %h required %h", rd, exp_perf); end
  endtask

  task automatic test_busy_write();
    logic [31:0] rd;
    mmio_write(A_CTRL, 32'h4);
    mmio_write(A_LEN, 32'd8);
    out_ready = 1'b0;
    push_stream(8);
    mmio_write(A_CTRL, 32'h1);
    mmio_write(A_BUF, 32'h0000_00FF);   // dropped, model untouched
    mmio_write(A_LEN, 32'd3);           // dropped
    mmio_write(A_CTRL, 32'h1);          // START while busy: ignored
    mmio_read(A_STATUS, rd);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL busy_err_status: got %h required %h", rd, 32'h5); end
    out_ready = 1'b1;
    wait_drain(50, 1'b0);
    mmio_read(A_LEN, rd);
    checks++; if (rd !== 32'd8) begin errors++; $display("FAIL busy_len_kept: got %h required %h", rd, 32'd8); end
    mmio_read(A_BUF, rd);
    checks++; if (rd !== {24'h0, model_buf[0]}) begin errors++; $display("FAIL busy_buf_kept: got %h required %h", rd, {24'h0, model_buf[0]}); end
    mmio_write(A_CTRL, 32'h4);          // DONE_CLR leaves ERR set
    mmio_read(A_STATUS, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL err_sticky: got %h required %h", rd, 32'h4); end
    mmio_write(A_CTRL, 32'h2);
    mmio_read(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL soft_rst_clears_err: got %h required %h", rd, 32'h0); end
  endtask

  task automatic test_held_read();
    logic [3:0] seen;
    mmio_addr = A_STATUS; mmio_wdata = '0; mmio_wstrb = 4'hF; mmio_rd = 1'b1;
    seen = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      seen[c] = mmio_ready;
      if (c == 2) mmio_rd = 1'b0;      // held across two rising edges
      if (c < 3) tick();
    end
    tick();
    checks++;
    if (seen !== 4'b0010) begin
      errors++;
      $display("FAIL held_read_pulse: got ready pattern %b required %b", seen, 4'b0010);
    end
  endtask

  task automatic test_soft_rst();
    logic [31:0] rd;
    mmio_write(A_LEN, 32'd8);
    out_ready = 1'b0;
    push_stream(8);
    mmio_write(A_CTRL, 32'h1);
    mmio_write(A_CTRL, 32'h2);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL soft_rst_valid: got %b required 0", out_valid); end
    tick();
    exp_q.delete();
    out_ready = 1'b1;
    mmio_read(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL soft_rst_status: got %h required %h", rd, 32'h0); end
    mmio_read(A_LEN, rd);
    checks++; if (rd !== 32'd8) begin errors++; $display("FAIL soft_rst_len_kept: got %h required %h", rd, 32'd8); end
    mmio_write(A_LEN, 32'd0);
    mmio_write(A_CTRL, 32'h1);
    repeat (8) tick();                  // monitor flags any beat
    mmio_read(A_STATUS, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL len0_done: got %h required %h", rd, 32'h2); end
  endtask

  task automatic test_rst_mid_stream();
    logic [31:0] rd;
    mmio_write(A_LEN, 32'd8);
    out_ready = 1'b0;
    push_stream(8);
    mmio_write(A_CTRL, 32'h1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b required 0", out_valid); end
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    repeat (4) tick();
    mmio_read(A_LEN, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_len: got %h required %h", rd, 32'h0); end
  endtask

  task automatic test_len_bounds();
    logic [31:0] rd;
    mmio_write(A_LEN, 32'd257);
    mmio_read(A_LEN, rd);
    checks++; if (rd !== 32'd257) begin errors++; $display("FAIL len_9bit: got %h required %h", rd, 32'd257); end
    mmio_write(A_CTRL, 32'h1);
    repeat (6) tick();
    mmio_read(A_STATUS, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL len_over_err: got %h required %h", rd, 32'h4); end
    mmio_write(A_CTRL, 32'h2);
  endtask

  task automatic test_full();
    logic [31:0] rd;
    for (int i = 0; i < BUF_BYTES; i++) write_byte(i, 8'($urandom_range(0, 255)));
    mmio_write(A_LEN, 32'(BUF_BYTES));
    push_stream(BUF_BYTES);
    mmio_write(A_CTRL, 32'h1);
    wait_drain(2000, 1'b1);
    mmio_read(A_STATUS, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL full_done: got %h required %h", rd, 32'h2); end
  endtask

  task automatic test_back_to_back();
    int n;
    mmio_write(A_LEN, 32'd6);
    push_stream(6);
    mmio_write(A_CTRL, 32'h1);
    wait_drain(50, 1'b0);
    mmio_write(A_LEN, 32'd16);
    push_stream(16);
    mmio_write(A_CTRL, 32'h1);
    // First beat moved on the edge after START; three more follow, one per cycle.
    n = 0;
    while (out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL throughput: got %0d cycles required %0d", n, 3); end
    wait_drain(50, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_stall();
    test_busy_write();
    test_held_read();
    test_soft_rst();
    test_rst_mid_stream();
    test_len_bounds();
    test_full();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_beats: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
